// File: rtl/morse_player.sv
// morse_player: loadable Morse blinker driving one LED with exact unit timing.
// Plays dot/dash/letter-gap symbols from a latched sequence, one-shot or looped.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start, i_stop       load-and-play request, abort
//   i_repeat_en           loop forever with word gap when latched high
//   i_seq_in, i_seq_len   2-bit symbols (00 dot, 01 dash, 11 letter gap, 10 end), count
//   o_morse_led           LED drive, high only while marking
//   o_busy, o_done        not idle, one-shot completion pulse
//   o_sym_idx             index of symbol being played
module morse_player #(
    parameter int UNIT_CYCLES    = 10000,
    parameter int MAX_SYMS       = 32,
    parameter int LEN_W          = 6,
    parameter int DASH_UNITS     = 3,
    parameter int WORD_GAP_UNITS = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_repeat_en,
    input  logic [2*MAX_SYMS-1:0] i_seq_in,
    input  logic [LEN_W-1:0]      i_seq_len,
    output logic                  o_morse_led,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LEN_W-1:0]      o_sym_idx
);

    // Timer must hold the longest interval: dash, letter gap or word gap.
    localparam int M1        = (DASH_UNITS > 2) ? DASH_UNITS : 2;
    localparam int MAX_UNITS = (WORD_GAP_UNITS > M1) ? WORD_GAP_UNITS : M1;
    localparam int TW        = $clog2(MAX_UNITS * UNIT_CYCLES + 1);

    localparam logic [TW-1:0] T_UNIT = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T_DASH = TW'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T_LGAP = TW'(2 * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] T_WGAP = TW'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SYMS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_MARK  = 3'd2;
    localparam logic [2:0] S_SPACE = 3'd3;
    localparam logic [2:0] S_LGAP  = 3'd4;
    localparam logic [2:0] S_WGAP  = 3'd5;

    logic [2:0]            r_state;
    logic [TW-1:0]         r_timer;
    logic [LEN_W-1:0]      r_idx;
    logic [LEN_W-1:0]      r_len;
    logic [2*MAX_SYMS-1:0] r_seq;
    logic                  r_rep;
    logic                  r_done;

    logic [LEN_W-1:0]      w_len;
    logic [LEN_W-1:0]      w_nxt;
    logic [1:0]            w_sym;
    logic                  w_tdone;

    assign w_len   = (i_seq_len > MAX_LEN) ? MAX_LEN : i_seq_len;
    assign w_nxt   = r_idx + LEN_W'(1);
    assign w_tdone = (r_timer == '0);

    always_comb begin
        w_sym = 2'b10;
        for (int i = 0; i < MAX_SYMS; i++) begin
            if (r_idx == LEN_W'(i)) begin
                w_sym = r_seq[2*i +: 2];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_seq   <= '0;
            r_rep   <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_stop) begin
            // Abort also blocks a same-cycle start from IDLE.
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_seq <= i_seq_in;
                        r_len <= w_len;
                        r_rep <= i_repeat_en;
                        r_idx <= '0;
                        if (w_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    case (w_sym)
                        2'b00: begin
                            r_state <= S_MARK;
                            r_timer <= T_UNIT;
                        end
                        2'b01: begin
                            r_state <= S_MARK;
                            r_timer <= T_DASH;
                        end
                        2'b11: begin
                            r_state <= S_LGAP;
                            r_timer <= T_LGAP;
                        end
                        default: begin
                            // End code: same handling as reaching the length.
                            r_idx <= '0;
                            if (r_rep) begin
                                r_state <= S_WGAP;
                                r_timer <= T_WGAP;
                            end else begin
                                r_state <= S_IDLE;
                                r_timer <= '0;
                                r_done  <= 1'b1;
                            end
                        end
                    endcase
                end
                S_MARK: begin
                    if (w_tdone) begin
                        r_state <= S_SPACE;
                        r_timer <= T_UNIT;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_SPACE, S_LGAP: begin
                    if (!w_tdone) begin
                        r_timer <= r_timer - TW'(1);
                    end else if (w_nxt < r_len) begin
                        r_idx   <= w_nxt;
                        r_state <= S_FETCH;
                    end else begin
                        r_idx <= '0;
                        if (r_rep) begin
                            r_state <= S_WGAP;
                            r_timer <= T_WGAP;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_WGAP: begin
                    if (w_tdone) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign o_morse_led = (r_state == S_MARK);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_sym_idx   = r_idx;

endmodule

// File: tb/tb_morse_player.sv
// tb_morse_player: scoreboard bench for morse_player.
// A symbol-level model expands each sequence into per-cycle expected outputs.
module tb_morse_player;

    localparam int U  = 4;
    localparam int MS = 32;
    localparam int LW = 6;
    localparam int DU = 3;
    localparam int WG = 6;
    localparam int BIG = 100000;

    logic          clk = 1'b0;
    logic          reset, start, stop, rep;
    logic [2*MS-1:0] seq;
    logic [LW-1:0] len;
    logic          led, busy, done;
    logic [LW-1:0] idx;

    always #5 clk = ~clk;

    morse_player #(
        .UNIT_CYCLES(U), .MAX_SYMS(MS), .LEN_W(LW),
        .DASH_UNITS(DU), .WORD_GAP_UNITS(WG)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
        .i_repeat_en(rep), .i_seq_in(seq), .i_seq_len(len),
        .o_morse_led(led), .o_busy(busy), .o_done(done), .o_sym_idx(idx)
    );

    typedef struct packed {
        logic          led;
        logic          busy;
        logic          done;
        logic [LW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t plan[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic exp_t mk(input logic l, input logic b, input logic d, input int i);
        exp_t e;
        e.led  = l;
        e.busy = b;
        e.done = d;
        e.idx  = LW'(i);
        return e;
    endfunction

    task automatic push_n(input int n, input exp_t e);
        repeat (n) plan.push_back(e);
    endtask

    // Expected timeline, one entry per clock after start is sampled.
    task automatic model(input logic [2*MS-1:0] s, input int l, input bit r, input int maxc);
        int  L;
        bit  ended;
        logic [1:0] code;
        plan.delete();
        L = (l > MS) ? MS : l;
        if (L == 0) begin
            plan.push_back(mk(0, 0, 1, 0));
            return;
        end
        while (plan.size() < maxc) begin
            ended = 0;
            for (int i = 0; i < L && !ended; i++) begin
                code = s[2*i +: 2];
                plan.push_back(mk(0, 1, 0, i));
                case (code)
                    2'b00: begin push_n(U, mk(1, 1, 0, i)); push_n(U, mk(0, 1, 0, i)); end
                    2'b01: begin push_n(DU*U, mk(1, 1, 0, i)); push_n(U, mk(0, 1, 0, i)); end
                    2'b11: push_n(2*U, mk(0, 1, 0, i));
                    default: ended = 1;
                endcase
            end
            if (!r) begin
                plan.push_back(mk(0, 0, 1, 0));
                break;
            end
            push_n(WG*U, mk(0, 1, 0, 0));
        end
        while (plan.size() > maxc) void'(plan.pop_back());
    endtask

    task automatic run(input logic [2*MS-1:0] s, input int l, input bit r,
                       input int stop_at, input int maxc, input bit junk);
        int n;
        model(s, l, r, maxc);
        n = plan.size();
        if (stop_at > 0 && stop_at < n) n = stop_at;
        @(negedge clk);
        seq = s; len = LW'(l); rep = r; start = 1'b1; stop = 1'b0;
        exp_q.push_back(plan[0]);
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            start = junk && plan[k-1].busy && ($urandom_range(0, 7) == 0);
            if (junk) begin
                seq = {$urandom(), $urandom()};
                len = LW'($urandom_range(0, 63));
                rep = 1'($urandom_range(0, 1));
            end
            exp_q.push_back(plan[k]);
        end
        if (stop_at > 0) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b1;
            exp_q.push_back(mk(0, 0, 0, 0));
        end
        repeat (2) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            exp_q.push_back(mk(0, 0, 0, 0));
        end
    endtask

    // Monitor: compares one expected entry per clock whenever one is queued.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {led, busy, done, idx};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d t=%0t: got led=%b busy=%b done=%b idx=%0d, want led=%b busy=%b done=%b idx=%0d",
                             vectors, $time, a.led, a.busy, a.done, a.idx,
                             e.led, e.busy, e.done, e.idx);
                end
            end
        end
    end

    function automatic logic [2*MS-1:0] rand_seq();
        logic [2*MS-1:0] s;
        int r;
        s = '0;
        for (int i = 0; i < MS; i++) begin
            r = $urandom_range(0, 15);
            s[2*i +: 2] = (r == 0) ? 2'b10 : (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : 2'b11;
        end
        return s;
    endfunction

    initial begin
        logic [2*MS-1:0] a_seq;
        logic [2*MS-1:0] s;
        int l;
        int mc;
        a_seq = '0;
        a_seq[3:0] = 4'b0100;
        reset = 1'b1; start = 1'b0; stop = 1'b0; rep = 1'b0;
        seq = '0; len = '0;

        repeat (3) begin
            @(negedge clk);
            reset = 1'b1;
            exp_q.push_back(mk(0, 0, 0, 0));
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));

        // "A" one-shot, then looped with stop inside the second pass.
        run(a_seq, 2, 0, 0, BIG, 0);
        run(a_seq, 2, 1, 60, 60, 0);
        // Dot, letter gap, early end, dash never reached.
        s = '0;
        s[7:0] = 8'b01_10_11_00;
        run(s, 4, 0, 0, BIG, 0);
        // Abort mid-dash, then restart from symbol 0.
        run(a_seq, 2, 0, 14, BIG, 0);
        run(a_seq, 2, 0, 0, BIG, 0);
        // Zero length and clamped length.
        run(a_seq, 0, 0, 0, BIG, 0);
        run('0, 40, 0, 0, BIG, 0);
        // Start pulses and input churn while busy.
        run(a_seq, 2, 0, 0, BIG, 1);

        // Start and stop together in IDLE: stop wins.
        @(negedge clk);
        seq = a_seq; len = 2; rep = 0; start = 1'b1; stop = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0));
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));

        // Reset during MARK, with start held while reset is high.
        model(a_seq, 2, 0, BIG);
        @(negedge clk);
        seq = a_seq; len = 2; rep = 0; start = 1'b1;
        exp_q.push_back(plan[0]);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            exp_q.push_back(plan[k]);
        end
        repeat (2) begin
            @(negedge clk);
            reset = 1'b1; start = 1'b1;
            exp_q.push_back(mk(0, 0, 0, 0));
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0));

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            s = rand_seq();
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 63) : $urandom_range(0, 12);
            if ($urandom_range(0, 2) == 0) begin
                mc = $urandom_range(20, 400);
                run(s, l, 1, mc, mc, 1);
            end else if ($urandom_range(0, 4) == 0) begin
                run(s, l, 0, $urandom_range(1, 150), BIG, 1);
            end else begin
                run(s, l, 0, 0, BIG, 1);
            end
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
